// File: rtl/usb_line_pkg.sv
// Shared types for the USB line monitor: decoded bus line states, the EOP/reset
// FSM states, and the pin-pair to line-state decoder.
package usb_line_pkg;

  typedef enum logic [1:0] {
    LS_SE0 = 2'd0,
    LS_J   = 2'd1,
    LS_K   = 2'd2,
    LS_SE1 = 2'd3
  } line_state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SE0_RUN,
    ST_EOP_J,
    ST_BUS_RST
  } mon_state_t;

  // J is the differential state with D+ high at full speed and D- high at low speed.
  function automatic line_state_t decode_line(input logic dp, input logic dm,
                                              input logic low_speed);
    line_state_t ls;
    if (dp == dm) begin
      ls = dp ? LS_SE1 : LS_SE0;
    end else begin
      ls = (dp ^ low_speed) ? LS_J : LS_K;
    end
    return ls;
  endfunction

endpackage

// File: rtl/usb_line_sync.sv
// Brings raw D+/D- into the clock domain and registers the decoded line state.
module usb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_d_plus,
  input  logic       i_d_minus,
  input  logic       i_low_speed,
  output logic [1:0] o_ls
);
  import usb_line_pkg::*;

  logic [SYNC_STAGES-1:0] r_dp_sync;
  logic [SYNC_STAGES-1:0] r_dm_sync;
  line_state_t            r_ls;

  // Polarity is applied at decode time, so a low_speed change affects the next sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dp_sync <= '0;
      r_dm_sync <= '0;
      r_ls      <= LS_SE0;
    end else begin
      r_dp_sync <= {r_dp_sync[SYNC_STAGES-2:0], i_d_plus};
      r_dm_sync <= {r_dm_sync[SYNC_STAGES-2:0], i_d_minus};
      r_ls      <= decode_line(r_dp_sync[SYNC_STAGES-1], r_dm_sync[SYNC_STAGES-1],
                               i_low_speed);
    end
  end

  assign o_ls = r_ls;

endmodule

// File: rtl/usb_line_monitor.sv
// USB line monitor: classifies SE0 runs into EOP, malformed EOP or bus reset,
// and flags suspend (long J idle) and SE1 entry.
module usb_line_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int EOP_MIN     = 8,
  parameter int EOP_MAX     = 24,
  parameter int J_MIN       = 4,
  parameter int RESET_MIN   = 100,
  parameter int SUSPEND_MIN = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_plus,
  input  logic       d_minus,
  input  logic       low_speed,
  output logic [1:0] line_state,
  output logic       rx_eop,
  output logic       eop_err,
  output logic       se1_err,
  output logic       bus_reset,
  output logic       suspend
);
  import usb_line_pkg::*;

  generate
    if (!(SYNC_STAGES >= 2 && SYNC_STAGES < EOP_MIN && EOP_MIN <= EOP_MAX &&
          EOP_MAX < RESET_MIN && J_MIN >= 1)) begin : g_bad_params
      $error("usb_line_monitor: illegal parameter combination");
    end
  endgenerate

  localparam int SE0_W  = $clog2(RESET_MIN + 1);
  localparam int JCNT_W = $clog2(J_MIN + 1);
  localparam int JRUN_W = $clog2(SUSPEND_MIN + 1);
  localparam logic [SE0_W-1:0]  SE0_EOP_MIN = SE0_W'(EOP_MIN);
  localparam logic [SE0_W-1:0]  SE0_EOP_MAX = SE0_W'(EOP_MAX);
  localparam logic [SE0_W-1:0]  SE0_RESET   = SE0_W'(RESET_MIN);
  localparam logic [JCNT_W-1:0] JCNT_DONE   = JCNT_W'(J_MIN);
  localparam logic [JRUN_W-1:0] JRUN_SUSP   = JRUN_W'(SUSPEND_MIN);

  logic [1:0]  w_ls_raw;
  line_state_t w_ls;

  usb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .i_d_plus   (d_plus),
    .i_d_minus  (d_minus),
    .i_low_speed(low_speed),
    .o_ls       (w_ls_raw)
  );

  assign w_ls = line_state_t'(w_ls_raw);

  mon_state_t        r_state, w_state_next;
  logic [SE0_W-1:0]  r_se0_cnt, w_se0_cnt_next, w_se0_inc;
  logic [JCNT_W-1:0] r_j_cnt, w_j_cnt_next, w_j_inc;
  logic [JRUN_W-1:0] r_jrun, w_jrun_next;
  line_state_t       r_ls_prev;
  logic              w_rx_eop_next, w_eop_err_next;
  logic              r_rx_eop, r_eop_err, r_se1_err, r_bus_reset, r_suspend;

  assign w_se0_inc = (r_se0_cnt == SE0_RESET) ? r_se0_cnt : r_se0_cnt + SE0_W'(1);
  assign w_j_inc   = r_j_cnt + JCNT_W'(1);

  always_comb begin
    w_state_next   = r_state;
    w_se0_cnt_next = r_se0_cnt;
    w_j_cnt_next   = r_j_cnt;
    w_rx_eop_next  = 1'b0;
    w_eop_err_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ls == LS_SE0) begin
          w_state_next   = ST_SE0_RUN;
          w_se0_cnt_next = SE0_W'(1);
        end
      end
      ST_SE0_RUN: begin
        if (w_ls == LS_SE0) begin
          w_se0_cnt_next = w_se0_inc;
          if (w_se0_inc == SE0_RESET) w_state_next = ST_BUS_RST;
        end else begin
          w_state_next   = ST_IDLE;
          w_se0_cnt_next = '0;
          // Short SE0 runs are line glitches and are dropped without comment.
          if (r_se0_cnt >= SE0_EOP_MIN) begin
            if (w_ls == LS_J && r_se0_cnt <= SE0_EOP_MAX) begin
              if (J_MIN == 1) begin
                w_rx_eop_next = 1'b1;
              end else begin
                w_state_next = ST_EOP_J;
                w_j_cnt_next = JCNT_W'(1);
              end
            end else begin
              w_eop_err_next = 1'b1;
            end
          end
        end
      end
      ST_EOP_J: begin
        if (w_ls == LS_J) begin
          if (w_j_inc == JCNT_DONE) begin
            w_rx_eop_next = 1'b1;
            w_state_next  = ST_IDLE;
            w_j_cnt_next  = '0;
          end else begin
            w_j_cnt_next = w_j_inc;
          end
        end else begin
          w_eop_err_next = 1'b1;
          w_j_cnt_next   = '0;
          if (w_ls == LS_SE0) begin
            w_state_next   = ST_SE0_RUN;
            w_se0_cnt_next = SE0_W'(1);
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      ST_BUS_RST: begin
        if (w_ls != LS_SE0) begin
          w_state_next   = ST_IDLE;
          w_se0_cnt_next = '0;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_jrun_next = (w_ls != LS_J)        ? '0 :
                       (r_jrun == JRUN_SUSP) ? r_jrun : r_jrun + JRUN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_se0_cnt   <= '0;
      r_j_cnt     <= '0;
      r_jrun      <= '0;
      r_ls_prev   <= LS_SE0;
      r_rx_eop    <= 1'b0;
      r_eop_err   <= 1'b0;
      r_se1_err   <= 1'b0;
      r_bus_reset <= 1'b0;
      r_suspend   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_se0_cnt   <= w_se0_cnt_next;
      r_j_cnt     <= w_j_cnt_next;
      r_jrun      <= w_jrun_next;
      r_ls_prev   <= w_ls;
      r_rx_eop    <= w_rx_eop_next;
      r_eop_err   <= w_eop_err_next;
      r_se1_err   <= (w_ls == LS_SE1) && (r_ls_prev != LS_SE1);
      r_bus_reset <= (w_state_next == ST_BUS_RST);
      r_suspend   <= (w_jrun_next == JRUN_SUSP);
    end
  end

  assign line_state = w_ls_raw;
  assign rx_eop     = r_rx_eop;
  assign eop_err    = r_eop_err;
  assign se1_err    = r_se1_err;
  assign bus_reset  = r_bus_reset;
  assign suspend    = r_suspend;

endmodule

// File: tb/tb_usb_line_monitor.sv
// Bench for usb_line_monitor: directed scenarios with hand-counted results, then
// random line activity checked every cycle against a run-length history model.
module tb_usb_line_monitor;
  localparam int SYNC_STAGES = 2;
  localparam int EOP_MIN     = 8;
  localparam int EOP_MAX     = 24;
  localparam int J_MIN       = 4;
  localparam int RESET_MIN   = 100;
  localparam int SUSPEND_MIN = 200;
  localparam int HIST_CAP    = 1024;
  localparam logic [1:0] SE0 = 2'd0, JS = 2'd1, KS = 2'd2, SE1 = 2'd3;

  logic clk = 1'b0, rst = 1'b1;
  logic d_plus = 1'b0, d_minus = 1'b0, low_speed = 1'b0;
  logic [1:0] line_state;
  logic rx_eop, eop_err, se1_err, bus_reset, suspend;

  always #5 clk = ~clk;

  usb_line_monitor #(
    .SYNC_STAGES(SYNC_STAGES), .EOP_MIN(EOP_MIN), .EOP_MAX(EOP_MAX),
    .J_MIN(J_MIN), .RESET_MIN(RESET_MIN), .SUSPEND_MIN(SUSPEND_MIN)
  ) dut (
    .clk(clk), .rst(rst), .d_plus(d_plus), .d_minus(d_minus), .low_speed(low_speed),
    .line_state(line_state), .rx_eop(rx_eop), .eop_err(eop_err), .se1_err(se1_err),
    .bus_reset(bus_reset), .suspend(suspend)
  );

  int errors = 0, checks = 0;
  int cyc = 0;
  bit model_valid = 0;
  logic [1:0] hist[$];              // decoded line states since the last reset
  logic [1:0] raw_pipe[SYNC_STAGES];
  logic [1:0] exp_ls;
  logic exp_rx, exp_err, exp_se1, exp_bus, exp_susp;
  int n_rx, n_err, n_se1, n_bus, n_susp, last_rx_cyc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [1:0] line_of(input logic dp, input logic dm, input logic lsp);
    logic j_pin;
    if (!dp && !dm) return SE0;
    if (dp && dm) return SE1;
    j_pin = lsp ? dm : dp;
    return j_pin ? JS : KS;
  endfunction

  function automatic int run_len(input logic [1:0] sym, input int idx);
    int n = 0;
    for (int i = idx; i >= 0; i--) begin
      if (hist[i] != sym) break;
      n++;
    end
    return n;
  endfunction

  function automatic bit valid_eop(input int idx);
    int len;
    if (idx < 0) return 0;
    if (hist[idx] != SE0) return 0;
    len = run_len(SE0, idx);
    return (len >= EOP_MIN) && (len <= EOP_MAX);
  endfunction

  function automatic bit all_j(input int lo, input int hi);
    if (lo < 0) return 0;
    for (int i = lo; i <= hi; i++) if (hist[i] != JS) return 0;
    return 1;
  endfunction

  // Model: outputs after an edge depend on the decoded history up to the previous edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      hist.delete();
      hist.push_back(SE0);
      for (int i = 0; i < SYNC_STAGES; i++) raw_pipe[i] = 2'b00;
      exp_ls = SE0; exp_rx = 0; exp_err = 0; exp_se1 = 0; exp_bus = 0; exp_susp = 0;
      model_valid = 1;
    end else if (model_valid) begin
      int n, len, jr;
      logic [1:0] cur, nls;
      n   = hist.size() - 1;
      cur = hist[n];
      exp_rx  = (n >= J_MIN) && all_j(n - J_MIN + 1, n) && valid_eop(n - J_MIN);
      exp_err = 0;
      if (cur != SE0 && n >= 1 && hist[n-1] == SE0) begin
        len = run_len(SE0, n - 1);
        if (len >= EOP_MIN && len < RESET_MIN && (len > EOP_MAX || cur != JS)) exp_err = 1;
      end
      if (cur != JS && n >= 1 && hist[n-1] == JS) begin
        jr = run_len(JS, n - 1);
        if (jr < J_MIN && valid_eop(n - 1 - jr)) exp_err = 1;
      end
      exp_bus  = (cur == SE0) && (run_len(SE0, n) >= RESET_MIN);
      exp_susp = (cur == JS) && (run_len(JS, n) >= SUSPEND_MIN);
      exp_se1  = (cur == SE1) && (n == 0 || hist[n-1] != SE1);
      nls = line_of(raw_pipe[SYNC_STAGES-1][1], raw_pipe[SYNC_STAGES-1][0], low_speed);
      for (int i = SYNC_STAGES - 1; i > 0; i--) raw_pipe[i] = raw_pipe[i-1];
      raw_pipe[0] = {d_plus, d_minus};
      hist.push_back(nls);
      if (hist.size() > HIST_CAP) void'(hist.pop_front());
      exp_ls = nls;
    end
  end

  initial forever begin
    @(negedge clk);
    if (model_valid) begin
      chk("line_state", line_state, exp_ls);
      chk("rx_eop", rx_eop, exp_rx);
      chk("eop_err", eop_err, exp_err);
      chk("se1_err", se1_err, exp_se1);
      chk("bus_reset", bus_reset, exp_bus);
      chk("suspend", suspend, exp_susp);
      chk("rx_eop_and_eop_err", rx_eop & eop_err, 0);
      if (rx_eop) begin n_rx++; last_rx_cyc = cyc; end
      if (eop_err) n_err++;
      if (se1_err) n_se1++;
      if (bus_reset) n_bus++;
      if (suspend) n_susp++;
    end
  end

  task automatic drive(input logic [1:0] sym, input int n);
    for (int i = 0; i < n; i++) begin
      case (sym)
        SE0:     {d_plus, d_minus} = 2'b00;
        SE1:     {d_plus, d_minus} = 2'b11;
        JS:      {d_plus, d_minus} = low_speed ? 2'b01 : 2'b10;
        default: {d_plus, d_minus} = low_speed ? 2'b10 : 2'b01;
      endcase
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_tally();
    n_rx = 0; n_err = 0; n_se1 = 0; n_bus = 0; n_susp = 0; last_rx_cyc = -1;
  endtask

  task automatic eop_case(input string name, input int se0_len, input int j_len,
                          input logic [1:0] after, input int want_rx, input int want_err);
    int first_j;
    drive(JS, 8);
    clear_tally();
    drive(SE0, se0_len);
    first_j = cyc + 1;
    drive(JS, j_len);
    drive(after, 4);
    drive(JS, 12);
    $display("case %s: rx_eop=%0d eop_err=%0d", name, n_rx, n_err);
    chk({name, "_rx_count"}, n_rx, want_rx);
    chk({name, "_err_count"}, n_err, want_err);
    if (want_rx == 1) chk({name, "_latency"}, last_rx_cyc - first_j, SYNC_STAGES + J_MIN);
  endtask

  initial begin
    int r, len, sym;
    int lens[14];
    lens = '{1, 2, 3, J_MIN - 1, J_MIN, EOP_MIN - 1, EOP_MIN, EOP_MIN + 1,
             EOP_MAX, EOP_MAX + 1, 16, 5, RESET_MIN - 1, RESET_MIN};
    clear_tally();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_line_state", line_state, SE0);
    chk("reset_outputs", {rx_eop, eop_err, se1_err, bus_reset, suspend}, 0);

    eop_case("eop_good_16", 16, 12, JS, 1, 0);
    eop_case("glitch_5", 5, 12, JS, 0, 0);
    eop_case("too_long_30", 30, 12, JS, 0, 1);
    eop_case("j2_then_k", 16, 2, KS, 0, 1);
    eop_case("eop_min_edge", EOP_MIN, 12, JS, 1, 0);
    eop_case("eop_max_edge", EOP_MAX, 12, JS, 1, 0);

    drive(JS, 8);
    clear_tally();
    drive(SE0, 150);
    drive(JS, 12);
    $display("case bus_reset_150: bus_reset_cycles=%0d rx=%0d err=%0d", n_bus, n_rx, n_err);
    chk("bus_reset_cycles", n_bus, 151 - RESET_MIN);
    chk("bus_reset_no_rx", n_rx, 0);
    chk("bus_reset_no_err", n_err, 0);

    drive(JS, 8);
    clear_tally();
    drive(SE0, 16); drive(JS, 2);
    rst = 1'b1; drive(JS, 1); rst = 1'b0;
    drive(JS, 12);
    $display("case reset_mid_eop: rx=%0d err=%0d", n_rx, n_err);
    chk("reset_mid_eop_pulses", n_rx + n_err, 0);

    for (int lsp = 0; lsp < 2; lsp++) begin
      low_speed = lsp[0];
      drive(KS, 8);
      clear_tally();
      drive(JS, 250);
      drive(SE1, 1);
      drive(KS, 8);
      $display("case suspend low_speed=%0d: suspend_cycles=%0d se1_err=%0d", lsp, n_susp, n_se1);
      chk("suspend_cycles", n_susp, 251 - SUSPEND_MIN);
      chk("se1_err_count", n_se1, 1);
      chk("suspend_no_eop_events", n_rx + n_err, 0);
    end
    low_speed = 1'b0;

    for (int s = 0; s < 400; s++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        low_speed = ~low_speed;
      end else if (r < 4) begin
        rst = 1'b1;
        drive($urandom_range(0, 3), $urandom_range(1, 2));
        rst = 1'b0;
      end else if (r < 5) begin
        drive(JS, SUSPEND_MIN + $urandom_range(0, 20));
      end
      r = $urandom_range(0, 99);
      sym = (r < 35) ? SE0 : (r < 70) ? JS : (r < 90) ? KS : SE1;
      len = lens[$urandom_range(0, 11)];
      if ($urandom_range(0, 19) == 0) len = lens[$urandom_range(12, 13)];
      drive(sym[1:0], len);
    end
    drive(JS, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_line_monitor.md
USB_LINE_MONITOR -- requirements
Module: usb_line_monitor

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: input synchronizer depth.
REQ-002 SHALL have parameter EOP_MIN, default 8: minimum SE0 run, in clk cycles, accepted as EOP.
REQ-003 SHALL have parameter EOP_MAX, default 24: maximum SE0 run, in clk cycles, accepted as EOP.
REQ-004 SHALL have parameter J_MIN, default 4: number of consecutive J samples required after SE0 to complete an EOP.
REQ-005 SHALL have parameter RESET_MIN, default 100: SE0 run length, in clk cycles, that signals a bus reset.
REQ-006 SHALL have parameter SUSPEND_MIN, default 200: J run length, in clk cycles, that signals suspend.
REQ-007 SHALL have ports, clock and reset first:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- d_plus  in  1  raw D+.
- d_minus  in  1  raw D-.
- low_speed  in  1  J polarity select: 0 = J is D+ high; 1 = J is D- high.
- line_state  out  2  synchronized decoded line state.
- rx_eop  out  1  one-cycle pulse on a valid EOP.
- eop_err  out  1  one-cycle pulse on a malformed EOP.
- se1_err  out  1  one-cycle pulse on entry to SE1.
- bus_reset  out  1  level, high during a long SE0.
- suspend  out  1  level, high during a long J idle.
REQ-008 SHALL fail elaboration unless 2 <= SYNC_STAGES < EOP_MIN <= EOP_MAX < RESET_MIN and J_MIN >= 1.

Function
REQ-009 SHALL pass d_plus and d_minus through SYNC_STAGES flops and then decode them to ls: 00 = SE0, J, K, 11 = SE1; J and K are per low_speed.
REQ-010 SHALL drive line_state = ls.
REQ-011 SHALL run an FSM with states IDLE, SE0_RUN, EOP_J and BUS_RST, and an SE0 counter that saturates at RESET_MIN; counts include the current sample.
REQ-012 In IDLE, ls = SE0 SHALL move the FSM to SE0_RUN with count 1.
REQ-013 In SE0_RUN, continued SE0 SHALL increment the count; reaching RESET_MIN SHALL move the FSM to BUS_RST.
REQ-014 In SE0_RUN, a J with count in [EOP_MIN, EOP_MAX] SHALL move the FSM to EOP_J with J count 1.
REQ-015 In SE0_RUN, a non-SE0 sample with count < EOP_MIN SHALL return the FSM to IDLE silently (glitch filter).
REQ-016 In SE0_RUN, any other non-SE0 exit (count > EOP_MAX, or K/SE1 with count >= EOP_MIN) SHALL pulse eop_err and return the FSM to IDLE.
REQ-017 In EOP_J, J count reaching J_MIN SHALL pulse rx_eop and return the FSM to IDLE.
REQ-018 In EOP_J, a non-J sample SHALL pulse eop_err; SE0 SHALL move the FSM to SE0_RUN with count 1, and K/SE1 SHALL move it to IDLE.
REQ-019 bus_reset SHALL be high exactly while the FSM is in BUS_RST.
REQ-020 In BUS_RST, any non-SE0 sample SHALL move the FSM to IDLE and deassert bus_reset on the next edge, with no rx_eop or eop_err.
REQ-021 A J-run counter SHALL saturate at SUSPEND_MIN; suspend SHALL rise when the run reaches SUSPEND_MIN and clear on the first non-J sample.
REQ-022 se1_err SHALL pulse once per SE1 entry, independent of the FSM.
REQ-023 All outputs SHALL be registered.
REQ-024 rx_eop SHALL assert SYNC_STAGES + J_MIN edges after the first pin-level J sample.
REQ-025 A low_speed change SHALL take effect on the next decoded sample; no flush is required.
REQ-026 rx_eop and eop_err SHALL never assert in the same cycle.

Reset
REQ-027 rst SHALL set the synchronizer flops to 0, the FSM to IDLE, all counters to 0, and all outputs to 0, except line_state, which then decodes SE0.
REQ-028 The post-reset SE0 seen in the synchronizer SHALL be filtered by REQ-015, producing no pulses.
REQ-029 rst asserted mid-SE0 or mid-EOP_J SHALL abort with no pulse on the following cycle.

Structure
REQ-030 Package usb_line_pkg SHALL hold the line_state_t enum (SE0 = 0, J = 1, K = 2, SE1 = 3) and the FSM state enum.
REQ-031 Synchronizer plus decoder SHALL be sub-module usb_line_sync; counter widths SHALL be $clog2(limit + 1).

Verification (defaults; low_speed = 0)
REQ-032 SE0 16 cycles, then J held -> one rx_eop pulse exactly 6 edges after first J; eop_err stays 0.
REQ-033 SE0 5 cycles, then J -> no rx_eop, no eop_err.
REQ-034 SE0 30 cycles, then J -> one eop_err pulse; no rx_eop.
REQ-035 SE0 16 cycles, J 2 cycles, then K -> one eop_err pulse; no rx_eop.
REQ-036 SE0 150 cycles, then J -> bus_reset high from the 100th synchronized SE0 until one edge after J reaches ls; no rx_eop.
REQ-037 J held 250 cycles, then one SE1 cycle -> suspend rises at J run 200, clears after the SE1; se1_err pulses once; low_speed = 1 repeat with D- as J gives identical results.
